// File: rtl/riscv_pkg.sv
// Shared core definitions: funct3 access-size codes
// and the load/store unit FSM state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT
  } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// Load lane select and sign/zero extension.
// Purely combinational; unknown sizes return zero.
import riscv_pkg::*;

module load_extend (
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  // pick the addressed lane, then widen it
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    unique case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_W:    result = rdata;
      F3_BU:   result = {24'b0, b};
      F3_HU:   result = {16'b0, h};
      default: result = 32'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: dmem handshake, store
// alignment, load extension, stall and bubble gating.
import riscv_pkg::*;

module mem_stage_lsu #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        RegWriteM,
  output logic        RegWriteMO,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  lsu_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [29:0] r_addr;
  logic [1:0]  r_off;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [2:0]  r_f3;

  logic        access;
  logic        bad;
  logic        legal;
  logic        idle;
  logic        tmo;
  logic        done;
  logic [3:0]  be_in;
  logic [31:0] wd_in;
  logic [2:0]  x_f3;
  logic [1:0]  x_off;
  logic [31:0] ext;

  assign access = MemReadM | MemWriteM;
  assign idle   = (state == IDLE);

  // size/alignment legality of the incoming access
  always_comb begin
    bad = 1'b0;
    unique case (funct3M)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = ALUResultM[0];
      F3_W:        bad = |ALUResultM[1:0];
      default:     bad = 1'b1;
    endcase
    if (MemWriteM && funct3M[2])
      bad = 1'b1;
  end

  assign legal = access & ~bad;

  // byte enables and lane-replicated store data
  always_comb begin
    unique case (funct3M[1:0])
      2'b00: begin
        be_in = 4'b0001 << ALUResultM[1:0];
        wd_in = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_in = 4'b0011 << ALUResultM[1:0];
        wd_in = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_in = 4'b1111;
        wd_in = WriteDataM;
      end
    endcase
  end

  // timeout on the last permitted wait cycle
  assign tmo = ~idle &
               (cnt == CNT_W'(MAX_WAIT - 1));

  assign dmem_req   = idle ? legal : ~tmo;
  assign dmem_we    = idle ? MemWriteM : r_we;
  assign dmem_addr  = idle ?
                      {ALUResultM[31:2], 2'b00} :
                      {r_addr, 2'b00};
  assign dmem_be    = idle ? be_in : r_be;
  assign dmem_wdata = idle ? wd_in : r_wdata;

  assign x_f3  = idle ? funct3M : r_f3;
  assign x_off = idle ? ALUResultM[1:0] : r_off;

  load_extend u_ext (
    .funct3 (x_f3),
    .off    (x_off),
    .rdata  (dmem_rdata),
    .result (ext)
  );

  assign done       = dmem_req & dmem_ready;
  assign StallM     = dmem_req & ~dmem_ready;
  assign MisalignM  = idle & access & bad;
  assign BusErrM    = tmo;
  assign RegWriteMO = RegWriteM & ~StallM &
                      ~MisalignM & ~BusErrM;
  assign ReadDataM  = (done & ~dmem_we) ?
                      ext : 32'b0;

  // request latch, wait counter and state sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      r_addr  <= '0;
      r_off   <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (legal && !dmem_ready) begin
            state   <= WAIT;
            cnt     <= '0;
            r_addr  <= ALUResultM[31:2];
            r_off   <= ALUResultM[1:0];
            r_be    <= be_in;
            r_wdata <= wd_in;
            r_we    <= MemWriteM;
            r_f3    <= funct3M;
          end
        end
        WAIT: begin
          if (tmo || dmem_ready)
            state <= IDLE;
          else
            cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu with a
// behavioural access model and random traffic.
module tb_mem_stage_lsu;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  funct3M = 3'b0;
  logic [31:0] ALUResultM = 32'b0;
  logic [31:0] WriteDataM = 32'b0;
  logic        RegWriteM = 1'b0;
  logic        RegWriteMO;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'b0;
  logic        dmem_ready = 1'b0;

  mem_stage_lsu #(.MAX_WAIT(MW), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RegWriteM  (RegWriteM),
    .RegWriteMO (RegWriteMO),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready)
  );

  always #5 clk = ~clk;

  // kind: 0 completes, 1 misaligned, 2 bus error
  typedef struct {
    int          kind;
    int          stalls;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdo;
    logic        rwo;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int stalls = 0;
  int hold_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(
    input logic rd, input logic wr,
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd, input logic [31:0] rdat,
    input logic rw, input int d);
    exp_t e;
    int sz;
    int off;
    logic ok;
    logic [31:0] v;
    off = int'(a % 4);
    ok = (f3 == 0) || (f3 == 1) || (f3 == 2) ||
         (f3 == 4) || (f3 == 5);
    sz = 1 << f3[1:0];
    if (ok && (off % sz) != 0) ok = 1'b0;
    if (wr && f3 >= 4) ok = 1'b0;
    e.kind = 1; e.stalls = 0; e.we = wr;
    e.addr = a - 32'(off);
    e.be = 4'(((1 << sz) - 1) << off);
    if (sz == 1) e.wdata = (wd % 256) * 32'h01010101;
    else if (sz == 2) e.wdata = (wd % 65536) * 32'h00010001;
    else e.wdata = wd;
    e.rdo = 32'b0; e.rwo = 1'b0;
    if (!ok) return e;
    if (!rd && !wr) return e;
    if (d >= MW) begin
      e.kind = 2; e.stalls = MW;
      return e;
    end
    e.kind = 0; e.stalls = d; e.rwo = rw;
    if (!wr) begin
      v = rdat >> (8 * off);
      if (sz == 1) begin
        v = v % 256;
        if (f3 == 0 && v >= 128) v = v - 256;
      end else if (sz == 2) begin
        v = v % 65536;
        if (f3 == 1 && v >= 32768) v = v - 65536;
      end
      e.rdo = v;
    end
    return e;
  endfunction

  task automatic run_op(
    input logic rd, input logic wr,
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd, input logic [31:0] rdat,
    input logic rw, input int d);
    exp_t e;
    int n;
    e = model(rd, wr, f3, a, wd, rdat, rw, d);
    q.push_back(e);
    MemReadM = rd; MemWriteM = wr;
    funct3M = f3; ALUResultM = a;
    WriteDataM = wd; dmem_rdata = rdat;
    RegWriteM = rw;
    n = (e.kind == 1) ? 1 :
        (e.kind == 2) ? MW + 1 : d + 1;
    for (int i = 0; i < n; i++) begin
      dmem_ready = (e.kind == 1) ?
                   1'($urandom_range(0, 1)) : (i == d);
      @(posedge clk); #1;
    end
    MemReadM = 1'b0; MemWriteM = 1'b0;
    RegWriteM = 1'($urandom_range(0, 1));
    dmem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cyc();
    RegWriteM = 1'($urandom_range(0, 1));
    dmem_ready = 1'($urandom_range(0, 1));
    ALUResultM = $urandom;
    @(posedge clk); #1;
  endtask

  // monitor: pops the scoreboard on each response
  always @(negedge clk) begin
    exp_t e;
    int ka;
    int nev;
    if (reset) begin
      stalls = 0;
      hold_bad = 0;
    end else begin
      if (StallM) begin
        stalls++;
        if (q.size() > 0 &&
            (dmem_addr !== q[0].addr || !dmem_req))
          hold_bad++;
        if (RegWriteMO !== 1'b0) hold_bad++;
      end
      nev = int'(dmem_req && dmem_ready) +
            int'(MisalignM) + int'(BusErrM);
      if (nev > 0) begin
        ka = (nev > 1) ? 3 : BusErrM ? 2 :
             MisalignM ? 1 : 0;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_event kind=%0d at %0t",
                   ka, $time);
        end else begin
          e = q.pop_front();
          chk("kind", 32'(ka), 32'(e.kind));
          chk("stall_cycles", 32'(stalls), 32'(e.stalls));
          chk("hold_during_stall", 32'(hold_bad), 32'd0);
          chk("stall_at_end", 32'(StallM), 32'd0);
          chk("regwrite_o", 32'(RegWriteMO), 32'(e.rwo));
          chk("readdata", ReadDataM, e.rdo);
          chk("req", 32'(dmem_req), 32'(e.kind == 0));
          if (e.kind == 0) begin
            chk("we", 32'(dmem_we), 32'(e.we));
            chk("addr", dmem_addr, e.addr);
            chk("be", 32'(dmem_be), 32'(e.be));
            if (e.we) chk("wdata", dmem_wdata, e.wdata);
          end
        end
        stalls = 0;
        hold_bad = 0;
      end else if (!StallM && !MemReadM && !MemWriteM) begin
        chk("idle_req", 32'(dmem_req), 32'd0);
        chk("idle_regwrite", 32'(RegWriteMO), 32'(RegWriteM));
        chk("idle_readdata", ReadDataM, 32'd0);
      end
    end
  end

  logic [2:0] f3tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    logic rd, wr, rw;
    logic [2:0] f3;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_mis", 32'(MisalignM), 32'd0);
    chk("rst_buserr", 32'(BusErrM), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cyc();

    run_op(1, 0, 3'd2, 32'h100, 32'h0,
           32'hDEADBEEF, 1, 0);
    run_op(1, 0, 3'd0, 32'h103, 32'h0,
           32'h80FF0000, 1, 3);
    run_op(0, 1, 3'd1, 32'h0A2, 32'h1234ABCD,
           32'h0, 0, 0);
    run_op(1, 0, 3'd1, 32'h101, 32'h0, 32'h0, 1, 0);
    run_op(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 1, 0);
    run_op(1, 0, 3'd2, 32'h040, 32'h0,
           32'h55AA55AA, 1, MW + 2);
    run_op(1, 0, 3'd4, 32'h001, 32'h0,
           32'h00009C00, 1, 0);
    idle_cyc();

    MemReadM = 1'b1; funct3M = 3'd2;
    ALUResultM = 32'h200; RegWriteM = 1'b1;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    MemReadM = 1'b0;
    @(negedge clk);
    chk("post_rst_req", 32'(dmem_req), 32'd0);
    chk("post_rst_stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    run_op(0, 1, 3'd2, 32'h300, 32'hCAFEF00D,
           32'h0, 0, 1);

    for (int k = 0; k < 300; k++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 5) == 0)
        f3 = 3'($urandom_range(0, 7));
      else
        f3 = f3tab[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 2) != 0)
        a[1:0] = 2'b00;
      rw = wr ? 1'b0 : 1'($urandom_range(0, 1));
      run_op(rd, wr, f3, a, $urandom, $urandom, rw,
             int'($urandom_range(0, MW + 1)));
      repeat ($urandom_range(0, 2)) idle_cyc();
    end

    repeat (3) idle_cyc();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit for the MEM stage of the pipelined core. It sits between the EX/MEM pipeline register and the MEM/WB register (flopr4).
- Drives the data-memory request/ready handshake.
- Aligns store data and generates byte enables.
- Sign/zero-extends load data.
- Raises a stall while memory is busy.
- Gates RegWrite so that flopr4, which has no enable, captures a bubble during stalls and faults.

Parameters:
MAX_WAIT, 255, maximum WAIT-state cycles before the access is aborted with a bus error.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-high
MemReadM  in  1  load in MEM stage
MemWriteM  in  1  store in MEM stage
funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResultM  in  32  effective byte address
WriteDataM  in  32  store data, rs2 unshifted
RegWriteM  in  1  RegWrite from EX/MEM
RegWriteMO  out  1  gated RegWrite toward flopr4
ReadDataM  out  32  extended load data
StallM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
MisalignM  out  1  1-cycle misaligned/illegal-access flag
BusErrM  out  1  1-cycle timeout flag
dmem_req  out  1  request valid
dmem_we  out  1  1 = write
dmem_addr  out  32  word address, {ALUResultM[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-aligned store data
dmem_rdata  in  32  read word
dmem_ready  in  1  access completes this cycle

Behaviour:
- Access = MemReadM | MemWriteM. If both are high, the store wins.
- Alignment rules:
  - Misaligned if H/HU and addr[0]=1.
  - Misaligned if W and addr[1:0]!=0.
  - Illegal if funct3 is 011, 110 or 111, or if a store uses 100 or 101.
  - In all these cases: no request, MisalignM=1 for one cycle, RegWriteMO=0, ReadDataM=0, no stall.
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<addr[1:0].
  - W: 4'b1111.
- Store data: wdata replicated per size (B: {4{wd[7:0]}}, H: {2{wd[15:0]}}, W: wd).
- Load data: select the lane by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU). W is passed through unchanged.
- FSM states IDLE, WAIT.
  - IDLE with a legal access: dmem_req=1 combinationally from the inputs.
    - dmem_ready=1 the same cycle: zero-wait completion, StallM=0, ReadDataM valid, stay in IDLE.
    - dmem_ready=0: StallM=1, RegWriteMO=0. Latch addr, be, wdata, we and funct3 into request registers, clear the counter, go to WAIT.
  - WAIT: dmem_req=1 and all dmem_* outputs are driven from the latched registers, held stable until ready.
    - Each cycle without ready: increment the counter; StallM=1, RegWriteMO=0.
    - dmem_ready=1: StallM=0, ReadDataM extended from dmem_rdata using the latched funct3/addr[1:0], RegWriteMO=RegWriteM, go to IDLE.
    - Counter reaches MAX_WAIT without ready: BusErrM=1 for one cycle, dmem_req deasserts, StallM=0, RegWriteMO=0, ReadDataM=0, go to IDLE.
- No access in IDLE: dmem_req=0, RegWriteMO=RegWriteM, ReadDataM=0.
- dmem_ready outside a request is ignored.
- Reset (synchronous) resets all outputs and internal registers:
  - FSM goes to IDLE; counter and request registers go to 0.
  - StallM, dmem_req, MisalignM, BusErrM are 0 in the cycle after the reset edge.
  - Reset during WAIT abandons the access silently.
- Latency: a load completes in 0 added cycles if ready, otherwise in N stall cycles where N = cycles until ready, with N ≤ MAX_WAIT.

Decomposition:
- Shared package (riscv_pkg) holds:
  - funct3 size encodings as localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - An lsu_state_t enum {IDLE, WAIT}.
- One natural sub-module, load_extend: combinational lane select plus sign/zero extension (funct3, addr[1:0], rdata → 32-bit result), reused by any future cache path.
- Store alignment stays inline.

Test Plan:
- LW at 0x100, dmem_ready=1 the same cycle, rdata=0xDEADBEEF → ReadDataM=0xDEADBEEF, StallM=0, RegWriteMO=1, dmem_be=4'hF.
- LB at 0x103, rdata=0x80FF_0000, ready after 3 cycles → StallM=1 for 3 cycles with RegWriteMO=0; completion cycle ReadDataM=0xFFFFFF80, dmem_addr held at 0x100 throughout.
- SH at 0x0A2, WriteDataM=0x1234ABCD → dmem_we=1, dmem_be=4'b1100, dmem_wdata=0xABCDABCD, RegWriteMO=0 since RegWriteM=0 for stores.
- LH at 0x101, then LW at 0x102 → MisalignM=1 for each, dmem_req=0, ReadDataM=0, no stall.
- LW with dmem_ready held 0, MAX_WAIT=4 → StallM=1 for 4 cycles, then BusErrM=1 and FSM returns to IDLE; next LBU at 0x001 with rdata=0x0000_9C00 → 0x0000009C.
- Reset asserted on the 2nd WAIT cycle → next cycle dmem_req=0, StallM=0, state IDLE; a subsequent SW completes normally.
